ascii_hex_loader: RTL and testbench

//  Upstream stage of the terminal datapath. Consumes received ASCII bytes from the UART receiver
//  and assembles typed hex digits into a Width-bit value. Drives the parallel holding register:

---
 rtl/ascii_hex_loader_pkg.sv | 15 +
 rtl/ascii_hex_loader_decoder.sv | 22 ++
 rtl/ascii_hex_loader.sv | 133 +++++++++++++
 tb/tb_ascii_hex_loader.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/ascii_hex_loader_pkg.sv
// Shared terminal definitions: ASCII control codes and loader FSM state encodings.
package ascii_hex_loader_pkg;

   localparam logic [7:0] ASCII_BS    = 8'h08;
   localparam logic [7:0] ASCII_CR    = 8'h0D;
   localparam logic [7:0] ASCII_ESC   = 8'h1B;
   localparam logic [7:0] ASCII_QMARK = 8'h3F;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ACCUM = 2'd1,
      ST_ERR   = 2'd2
   } state_t;

endpackage

// File: rtl/ascii_hex_loader_decoder.sv
// hex_char_decoder: classifies an ASCII byte as a hex digit and yields its nibble value.
module hex_char_decoder (
   input  logic [7:0] rx_data_i,
   output logic       is_hex,
   output logic [3:0] nib
);

   always_comb begin
      is_hex = 1'b0;
      nib    = 4'h0;
      if (rx_data_i >= 8'h30 && rx_data_i <= 8'h39) begin
         is_hex = 1'b1;
         nib    = rx_data_i[3:0];
      end else if ((rx_data_i >= 8'h41 && rx_data_i <= 8'h46) ||
                   (rx_data_i >= 8'h61 && rx_data_i <= 8'h66)) begin
         // 'A'-'F' and 'a'-'f' share the low nibble 1..6
         is_hex = 1'b1;
         nib    = rx_data_i[3:0] + 4'd9;
      end
   end

endmodule

// File: rtl/ascii_hex_loader.sv
// Assembles typed hex digits into a Width-bit value; CR commits, ESC clears, BS edits.
// Optional echo path built only when ECHO_EN is defined.
module ascii_hex_loader
   import ascii_hex_loader_pkg::*;
#(
   parameter int Width = 12
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [7:0]       rx_data_i,
   input  logic             rx_valid_i,
   output logic [Width-1:0] value_o,
   output logic             load_o,
   output logic             clear_o,
   output logic             err_o,
   output logic [7:0]       tx_data_o,
   output logic             tx_valid_o
);

   localparam int Digits = Width / 4;
   localparam int CntW   = $clog2(Digits + 1);
   localparam logic [CntW-1:0] CntMax = CntW'(Digits);

   state_t           state;
   logic [Width-1:0] acc;
   logic [CntW-1:0]  cnt;
   logic             is_hex;
   logic [3:0]       nib;
   logic [Width+3:0] acc_shl;

   hex_char_decoder u_dec (
      .rx_data_i (rx_data_i),
      .is_hex    (is_hex),
      .nib       (nib)
   );

   assign acc_shl = {acc, nib};

   always_ff @(posedge clk_i) begin
      load_o  <= 1'b0;
      clear_o <= 1'b0;
`ifdef ECHO_EN
      tx_valid_o <= 1'b0;
`endif
      if (rst_i) begin
         state   <= ST_IDLE;
         acc     <= '0;
         cnt     <= '0;
         value_o <= '0;
         err_o   <= 1'b0;
`ifdef ECHO_EN
         tx_data_o <= 8'h00;
`endif
      end else if (rx_valid_i) begin
         if (rx_data_i == ASCII_ESC) begin
            clear_o <= 1'b1;
            err_o   <= 1'b0;
            acc     <= '0;
            cnt     <= '0;
            state   <= ST_IDLE;
`ifdef ECHO_EN
            tx_valid_o <= 1'b1;
            tx_data_o  <= rx_data_i;
`endif
         end else if (state == ST_ERR) begin
            // Only CR leaves the error state; everything else is swallowed silently
            if (rx_data_i == ASCII_CR) begin
               err_o <= 1'b0;
               acc   <= '0;
               cnt   <= '0;
               state <= ST_IDLE;
`ifdef ECHO_EN
               tx_valid_o <= 1'b1;
               tx_data_o  <= rx_data_i;
`endif
            end
         end else if (is_hex) begin
            if (cnt < CntMax) begin
               acc   <= acc_shl[Width-1:0];
               cnt   <= cnt + 1'b1;
               state <= ST_ACCUM;
`ifdef ECHO_EN
               tx_valid_o <= 1'b1;
               tx_data_o  <= rx_data_i;
`endif
            end else begin
               err_o <= 1'b1;
               state <= ST_ERR;
`ifdef ECHO_EN
               tx_valid_o <= 1'b1;
               tx_data_o  <= ASCII_QMARK;
`endif
            end
         end else if (rx_data_i == ASCII_BS) begin
            if (state == ST_ACCUM) begin
               acc <= acc >> 4;
               cnt <= cnt - 1'b1;
               if (cnt == CntW'(1))
                  state <= ST_IDLE;
`ifdef ECHO_EN
               tx_valid_o <= 1'b1;
               tx_data_o  <= rx_data_i;
`endif
            end
         end else if (rx_data_i == ASCII_CR) begin
            if (state == ST_ACCUM) begin
               value_o <= acc;
               load_o  <= 1'b1;
               acc     <= '0;
               cnt     <= '0;
               state   <= ST_IDLE;
            end
`ifdef ECHO_EN
            tx_valid_o <= 1'b1;
            tx_data_o  <= rx_data_i;
`endif
         end else begin
            err_o <= 1'b1;
            state <= ST_ERR;
`ifdef ECHO_EN
            tx_valid_o <= 1'b1;
            tx_data_o  <= ASCII_QMARK;
`endif
         end
      end
   end

`ifndef ECHO_EN
   assign tx_data_o  = 8'h00;
   assign tx_valid_o = 1'b0;
`endif

endmodule

// File: tb/tb_ascii_hex_loader.sv
// Directed bench for ascii_hex_loader: typed sequences with hand-computed expectations.
module tb_ascii_hex_loader;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic [7:0]  rx_data_i = 8'h00;
   logic        rx_valid_i = 1'b0;
   logic [11:0] value_o;
   logic        load_o;
   logic        clear_o;
   logic        err_o;
   logic [7:0]  tx_data_o;
   logic        tx_valid_o;

   int checks = 0;
   int failures = 0;

   ascii_hex_loader #(.Width(12)) dut (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .rx_data_i  (rx_data_i),
      .rx_valid_i (rx_valid_i),
      .value_o    (value_o),
      .load_o     (load_o),
      .clear_o    (clear_o),
      .err_o      (err_o),
      .tx_data_o  (tx_data_o),
      .tx_valid_o (tx_valid_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Called at a negedge; leaves the DUT response visible at the next negedge.
   task automatic send(input logic [7:0] b);
      rx_data_i  = b;
      rx_valid_i = 1'b1;
      @(negedge clk_i);
      rx_valid_i = 1'b0;
   endtask

   task automatic idle();
      @(negedge clk_i);
   endtask

   task automatic pulse_reset();
      rst_i = 1'b1;
      @(negedge clk_i);
      rst_i = 1'b0;
   endtask

   initial begin
      @(negedge clk_i);
      @(negedge clk_i);
      rst_i = 1'b0;
      check("rst_value", 32'(value_o), 32'h000);
      check("rst_load", 32'(load_o), 32'd0);
      check("rst_clear", 32'(clear_o), 32'd0);
      check("rst_err", 32'(err_o), 32'd0);
      check("rst_txv", 32'(tx_valid_o), 32'd0);
      check("rst_txd", 32'(tx_data_o), 32'h00);

      // 1: "1A3",CR
      send("1"); send("A"); send("3");
      check("t1_noload", 32'(load_o), 32'd0);
      send(8'h0D);
      check("t1_load", 32'(load_o), 32'd1);
      check("t1_value", 32'(value_o), 32'h1A3);
      check("t1_err", 32'(err_o), 32'd0);
      check("t1_clear", 32'(clear_o), 32'd0);
      idle();
      check("t1_load_drop", 32'(load_o), 32'd0);
      check("t1_value_hold", 32'(value_o), 32'h1A3);

      // 2: "ff",BS,"0",CR then a back-to-back CR
      send("f"); send("f"); send(8'h08); send("0"); send(8'h0D);
      check("t2_load", 32'(load_o), 32'd1);
      check("t2_value", 32'(value_o), 32'h0F0);
      send(8'h0D);
      check("t2_b2b_cr", 32'(load_o), 32'd0);
      check("t2_value_hold", 32'(value_o), 32'h0F0);

      // 3: "1234" overflows
      send("1"); send("2"); send("3");
      check("t3_err_pre", 32'(err_o), 32'd0);
      send("4");
      check("t3_err", 32'(err_o), 32'd1);
      send(8'h0D);
      check("t3_err_clr", 32'(err_o), 32'd0);
      check("t3_noload", 32'(load_o), 32'd0);
      check("t3_value", 32'(value_o), 32'h0F0);

      // 4: "7",ESC,CR
      send("7"); send(8'h1B);
      check("t4_clear", 32'(clear_o), 32'd1);
      check("t4_noload", 32'(load_o), 32'd0);
      send(8'h0D);
      check("t4_clear_drop", 32'(clear_o), 32'd0);
      check("t4_cr_noload", 32'(load_o), 32'd0);
      check("t4_err", 32'(err_o), 32'd0);
      check("t4_value", 32'(value_o), 32'h0F0);

      // 5: CR alone, illegal "G", ignored digit, recovery
      send(8'h0D);
      check("t5_cr_load", 32'(load_o), 32'd0);
      check("t5_cr_clear", 32'(clear_o), 32'd0);
      send("G");
      check("t5_err", 32'(err_o), 32'd1);
      send("5");
      check("t5_err_hold", 32'(err_o), 32'd1);
      send(8'h0D);
      check("t5_err_clr", 32'(err_o), 32'd0);
      check("t5_noload", 32'(load_o), 32'd0);
      send("5"); send(8'h0D);
      check("t5_load", 32'(load_o), 32'd1);
      check("t5_value", 32'(value_o), 32'h005);

      // BS in IDLE ignored; BS back to empty makes CR a no-op
      send(8'h08); send("9"); send(8'h0D);
      check("bs_idle_value", 32'(value_o), 32'h009);
      check("bs_idle_err", 32'(err_o), 32'd0);
      send("4"); send(8'h08); send(8'h0D);
      check("bs_empty_noload", 32'(load_o), 32'd0);
      check("bs_empty_value", 32'(value_o), 32'h009);

      // 6: reset mid-entry discards "AB"
      send("A"); send("B");
      pulse_reset();
      check("t6_rst_value", 32'(value_o), 32'h000);
      send("C");
`ifdef ECHO_EN
      check("t6_echo_c_v", 32'(tx_valid_o), 32'd1);
      check("t6_echo_c_d", 32'(tx_data_o), 32'h43);
`else
      check("t6_tx_idle_v", 32'(tx_valid_o), 32'd0);
`endif
      send(8'h0D);
`ifdef ECHO_EN
      check("t6_echo_cr_v", 32'(tx_valid_o), 32'd1);
      check("t6_echo_cr_d", 32'(tx_data_o), 32'h0D);
`else
      check("t6_tx_idle_d", 32'(tx_data_o), 32'h00);
`endif
      check("t6_load", 32'(load_o), 32'd1);
      check("t6_value", 32'(value_o), 32'h00C);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
